// File: rtl/fwd_hazard_unit_if.sv
// Bundle between ID/EX control and the forwarding/hazard unit.
// The master side drives ID tags and Flush; the slave returns Stall and the bypass selects.
interface fwd_hazard_unit_if #(
   parameter int ADDR_W    = 5,
   parameter int FWD_DEPTH = 2
);
   logic                 ID_Valid;
   logic [ADDR_W-1:0]    ID_rm;
   logic [ADDR_W-1:0]    ID_rn;
   logic [ADDR_W-1:0]    ID_rd;
   logic                 ID_RegWrite;
   logic                 ID_MemRead;
   logic                 Flush;
   logic                 Stall;
   logic [FWD_DEPTH-1:0] ForwardA;
   logic [FWD_DEPTH-1:0] ForwardB;

   modport master (
      output ID_Valid, ID_rm, ID_rn, ID_rd,
      output ID_RegWrite, ID_MemRead, Flush,
      input  Stall, ForwardA, ForwardB
   );

   modport slave (
      input  ID_Valid, ID_rm, ID_rn, ID_rd,
      input  ID_RegWrite, ID_MemRead, Flush,
      output Stall, ForwardA, ForwardB
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit with its own EX and post-EX tag pipeline.
// Bypass selects come from registered tags only; Stall is combinational from ID.
module fwd_hazard_unit #(
   parameter int ADDR_W    = 5,
   parameter int FWD_DEPTH = 2,
   parameter int LOAD_LAT  = 1,
   parameter bit ZERO_REG  = 1'b1
) (
   input logic              Clk,
   input logic              Reset_n,
   fwd_hazard_unit_if.slave hz
);

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rm;
      logic [ADDR_W-1:0] rn;
      logic [ADDR_W-1:0] rd;
      logic              rw;
      logic              mr;
   } ex_tag_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rd;
      logic              rw;
   } st_tag_t;

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   localparam logic [1:0] CNT_LOAD = 2'(LOAD_LAT - 1);
   localparam logic [FWD_DEPTH-1:0] ONE_HI =
      FWD_DEPTH'(1) << (FWD_DEPTH - 1);

   ex_tag_t              r_ex;
   st_tag_t              r_st [FWD_DEPTH];
   state_t               r_state;
   logic [1:0]           r_cnt;

   ex_tag_t              w_ex_nxt;
   logic                 w_hazard;
   logic                 w_stall;
   logic [FWD_DEPTH-1:0] w_fwd_a;
   logic [FWD_DEPTH-1:0] w_fwd_b;

   function automatic logic is_zero(logic [ADDR_W-1:0] r);
      return ZERO_REG && (r == '0);
   endfunction

   function automatic logic hit(
      st_tag_t           s,
      logic              ex_v,
      logic [ADDR_W-1:0] src
   );
      return ex_v & s.valid & s.rw & (s.rd == src) & ~is_zero(src);
   endfunction

   always_comb begin
      w_hazard = r_ex.valid & r_ex.mr & r_ex.rw & hz.ID_Valid
               & ~is_zero(r_ex.rd)
               & ((r_ex.rd == hz.ID_rm) | (r_ex.rd == hz.ID_rn));
   end

   assign w_stall = w_hazard | (r_cnt != 2'd0);

   // Oldest stage first so the youngest hit overwrites it.
   always_comb begin
      w_fwd_a = '0;
      w_fwd_b = '0;
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
         if (hit(r_st[k], r_ex.valid, r_ex.rm))
            w_fwd_a = ONE_HI >> k;
         if (hit(r_st[k], r_ex.valid, r_ex.rn))
            w_fwd_b = ONE_HI >> k;
      end
   end

   assign w_ex_nxt = '{
      valid: hz.ID_Valid & ~w_stall & ~hz.Flush,
      rm:    hz.ID_rm,
      rn:    hz.ID_rn,
      rd:    hz.ID_rd,
      rw:    hz.ID_RegWrite,
      mr:    hz.ID_MemRead
   };

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_ex <= '0;
         for (int k = 0; k < FWD_DEPTH; k++)
            r_st[k] <= '0;
      end else begin
         r_ex    <= w_ex_nxt;
         r_st[0] <= '{valid: r_ex.valid, rd: r_ex.rd, rw: r_ex.rw};
         for (int k = 1; k < FWD_DEPTH; k++)
            r_st[k] <= r_st[k-1];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
      end else if (hz.Flush) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_hazard && (LOAD_LAT > 1)) begin
                  r_cnt   <= CNT_LOAD;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               r_cnt <= r_cnt - 2'd1;
               if (r_cnt == 2'd1)
                  r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 2'd0;
            end
         endcase
      end
   end

   assign hz.Stall    = w_stall;
   assign hz.ForwardA = w_fwd_a;
   assign hz.ForwardB = w_fwd_b;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: DUT A (depth 2, load latency 1) table-driven,
// DUT B (depth 4, load latency 3) hand-written stall and reset sequences.
module tb_fwd_hazard_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;

   fwd_hazard_unit_if #(.ADDR_W(5), .FWD_DEPTH(2)) ia ();
   fwd_hazard_unit_if #(.ADDR_W(5), .FWD_DEPTH(4)) ib ();

   fwd_hazard_unit #(
      .ADDR_W(5), .FWD_DEPTH(2), .LOAD_LAT(1), .ZERO_REG(1'b1)
   ) u_a (
      .Clk(clk), .Reset_n(rst_a), .hz(ia.slave)
   );

   fwd_hazard_unit #(
      .ADDR_W(5), .FWD_DEPTH(4), .LOAD_LAT(3), .ZERO_REG(1'b1)
   ) u_b (
      .Clk(clk), .Reset_n(rst_b), .hz(ib.slave)
   );

   typedef struct {
      logic       v;
      logic [4:0] rm;
      logic [4:0] rn;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
      logic       fl;
      logic       st;
      logic [1:0] fa;
      logic [1:0] fb;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(
      logic v, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd,
      logic rw, logic mr, logic fl,
      logic st, logic [1:0] fa, logic [1:0] fb
   );
      vec_t r;
      r.v = v; r.rm = rm; r.rn = rn; r.rd = rd;
      r.rw = rw; r.mr = mr; r.fl = fl;
      r.st = st; r.fa = fa; r.fb = fb;
      return r;
   endfunction

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic drv_a(
      logic v, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd,
      logic rw, logic mr, logic fl
   );
      ia.ID_Valid = v; ia.ID_rm = rm; ia.ID_rn = rn; ia.ID_rd = rd;
      ia.ID_RegWrite = rw; ia.ID_MemRead = mr; ia.Flush = fl;
   endtask

   task automatic step_b(
      logic v, logic [4:0] rm, logic [4:0] rn, logic [4:0] rd,
      logic rw, logic mr
   );
      @(negedge clk);
      ib.ID_Valid = v; ib.ID_rm = rm; ib.ID_rn = rn; ib.ID_rd = rd;
      ib.ID_RegWrite = rw; ib.ID_MemRead = mr; ib.Flush = 1'b0;
      #2;
   endtask

   task automatic chk_b(string nm, logic st, logic [3:0] fa, logic [3:0] fb);
      chk({nm, ".stall"}, 8'(ib.Stall), 8'(st));
      chk({nm, ".fa"}, 8'(ib.ForwardA), 8'(fa));
      chk({nm, ".fb"}, 8'(ib.ForwardB), 8'(fb));
   endtask

   initial begin
      // v  rm  rn  rd  rw mr fl | st fa     fb
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 3, 6, 4, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 9, 3, 8, 1, 0, 0, 0, 2'b10, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 2, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 5, 5, 9, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 1, 2, 7, 1, 1, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 7, 3, 10, 1, 0, 0, 1, 2'b00, 2'b00));
      tbl.push_back(mk(1, 7, 3, 10, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00));
      tbl.push_back(mk(1, 1, 1, 11, 1, 1, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(1, 11, 11, 12, 1, 0, 1, 1, 2'b00, 2'b00));
      tbl.push_back(mk(1, 12, 11, 13, 1, 0, 0, 0, 2'b00, 2'b00));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

      rst_a = 1'b0;
      rst_b = 1'b0;
      drv_a(1, 3, 3, 3, 1, 1, 0);
      ib.ID_Valid = 1'b1; ib.ID_rm = 5'd3; ib.ID_rn = 5'd3;
      ib.ID_rd = 5'd3; ib.ID_RegWrite = 1'b1; ib.ID_MemRead = 1'b1;
      ib.Flush = 1'b0;
      #2;
      chk("rstA.stall", 8'(ia.Stall), 8'd0);
      chk("rstA.fa", 8'(ia.ForwardA), 8'd0);
      chk("rstA.fb", 8'(ia.ForwardB), 8'd0);
      chk_b("rstB", 1'b0, 4'h0, 4'h0);
      @(negedge clk);
      drv_a(0, 0, 0, 0, 0, 0, 0);
      ib.ID_Valid = 1'b0;
      rst_a = 1'b1;
      rst_b = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk);
         drv_a(tbl[i].v, tbl[i].rm, tbl[i].rn, tbl[i].rd,
               tbl[i].rw, tbl[i].mr, tbl[i].fl);
         #2;
         chk($sformatf("A%0d.stall", i), 8'(ia.Stall), 8'(tbl[i].st));
         chk($sformatf("A%0d.fa", i), 8'(ia.ForwardA), 8'(tbl[i].fa));
         chk($sformatf("A%0d.fb", i), 8'(ia.ForwardB), 8'(tbl[i].fb));
      end

      // Load latency 3: three stall cycles, then bypass from S[3]
      step_b(0, 0, 0, 0, 0, 0);
      chk_b("B.idle", 1'b0, 4'h0, 4'h0);
      step_b(1, 1, 1, 2, 1, 1);
      chk_b("B.lw", 1'b0, 4'h0, 4'h0);
      for (int c = 0; c < 4; c++) begin
         step_b(1, 4, 2, 3, 1, 0);
         chk_b($sformatf("B.hold%0d", c), (c < 3), 4'h0, 4'h0);
      end
      step_b(0, 0, 0, 0, 0, 0);
      chk_b("B.use", 1'b0, 4'h0, 4'b0001);
      step_b(0, 0, 0, 0, 0, 0);
      chk_b("B.drain", 1'b0, 4'h0, 4'h0);

      // Reset asserted while the counter holds 2
      step_b(1, 1, 1, 2, 1, 1);
      step_b(1, 2, 5, 6, 1, 0);
      chk_b("B.haz", 1'b1, 4'h0, 4'h0);
      step_b(1, 2, 5, 6, 1, 0);
      chk_b("B.cnt2", 1'b1, 4'h0, 4'h0);
      rst_b = 1'b0;
      #1;
      chk_b("B.rstmid", 1'b0, 4'h0, 4'h0);
      #1;
      rst_b = 1'b1;
      step_b(1, 2, 5, 6, 1, 0);
      chk_b("B.post0", 1'b0, 4'h0, 4'h0);
      step_b(0, 0, 0, 0, 0, 0);
      chk_b("B.post1", 1'b0, 4'h0, 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined core; successor to the two-stage combinational forwarding logic.
- Owns its own tag pipeline: captures source and destination register tags from ID and shifts them through EX and FWD_DEPTH later stages.
- Produces one-hot bypass selects for both EX operands and a load-use Stall, held for LOAD_LAT cycles.
- Sits beside the ID/EX pipeline register. Its outputs drive the EX operand muxes and the PC/IF-ID write enables.

Parameters:
- ADDR_W, 5, register address width.
- FWD_DEPTH, 2, number of post-EX stages that can forward (1..4). Stage 0 is EX/MEM, stage 1 is MEM/WB, stage 2 is WB+1, and so on.
- LOAD_LAT, 1, bubbles inserted on a load-use hazard (1..3).
- ZERO_REG, 1, when 1, register address 0 never forwards or stalls.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- ID_Valid  in  1  ID holds a real instruction.
- ID_rm  in  ADDR_W  ID source A register.
- ID_rn  in  ADDR_W  ID source B register.
- ID_rd  in  ADDR_W  ID destination register.
- ID_RegWrite  in  1  ID instruction writes the register file.
- ID_MemRead  in  1  ID instruction is a load.
- Flush  in  1  kill the instruction entering EX (branch taken).
- Stall  out  1  freeze PC and IF/ID, inject a bubble into EX.
- ForwardA  out  FWD_DEPTH  one-hot select for EX operand A.
- ForwardB  out  FWD_DEPTH  one-hot select for EX operand B.

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous and active-low.
  - Reset clears the EX tag, all stage tags (valid=0) and the stall counter.
  - Outputs in reset: Stall=0, ForwardA=0, ForwardB=0.
- Tag registers:
  - EX tag: {valid, rm, rn, rd, RegWrite, MemRead}.
  - Stage tag S[k] for k=0..FWD_DEPTH-1: {valid, rd, RegWrite, MemRead}.
- On every rising edge:
  - S[k] <= S[k-1] for k>=1.
  - S[0] <= the EX tag.
  - EX tag <= ID fields with valid=ID_Valid, unless Stall or Flush is asserted, in which case valid=0.
  - Flush takes priority over Stall for the EX tag.
  - S stages always shift; neither Stall nor Flush affects them.
- Forward select for operand A (ForwardB is identical, using the EX rn):
  - Stage k "hits" when S[k].valid & S[k].RegWrite & S[k].rd==EX.rm & EX.valid & !(ZERO_REG & rd==0).
  - Output bit (FWD_DEPTH-1-k) is set for the lowest-k hit only (youngest producer wins).
  - No hit gives all zeros (register file value).
  - For FWD_DEPTH=2: 2'b10 selects EX/MEM, 2'b01 selects MEM/WB.
  - Selects are combinational from registered tags only, with no dependence on ID inputs.
- Load-use detection (combinational):
  - Hazard when EX.valid & EX.MemRead & EX.RegWrite & ID_Valid & !(ZERO_REG & EX.rd==0) & (EX.rd==ID_rm | EX.rd==ID_rn).
- Stall state machine:
  - States are IDLE (counter 0) and HOLD (counter > 0).
  - IDLE: hazard asserts Stall in the same cycle. On the edge, if LOAD_LAT>1 the counter loads LOAD_LAT-1 and the FSM enters HOLD; otherwise it stays in IDLE.
  - HOLD: Stall=1 and the counter decrements each edge. On reaching 0 it returns to IDLE; ID re-evaluates hazards the following cycle.
  - Stall = hazard | (counter != 0).
  - Flush clears the counter to 0 on the edge. When Flush is high, Stall still reflects the current cycle's hazard/counter combinationally.
- Stage-k forwarding of a load:
  - A load in S[k] with k < LOAD_LAT-1 never reaches a consumer in EX, because the stall covers that window.
  - No extra check is required for this case.
- Reset mid-stall: asynchronous reset drops Stall immediately and invalidates all tags.

Test Plan:
1. ADD r3 in ID, then ADD using rm=r3 next cycle, FWD_DEPTH=2 -> consumer in EX gets ForwardA=2'b10, ForwardB=2'b00. One cycle later an ADD using rn=r3 in EX gets ForwardB=2'b01.
2. Producers r5 in both S[0] and S[1], consumer rm=rn=r5 -> ForwardA=ForwardB=2'b10 (youngest wins). Same with rd=0 and ZERO_REG=1 -> 2'b00.
3. LW r7 followed by ADD rm=r7, LOAD_LAT=1 -> Stall=1 for exactly 1 cycle and EX bubble valid=0. Next cycle ADD in EX sees ForwardA=2'b01.
4. LOAD_LAT=3, LW r2 then consumer rn=r2 -> Stall high for 3 consecutive cycles, then low. Consumer reaches EX with ForwardB matching the load's stage bit.
5. Load-use hazard with Flush=1 on the same edge -> EX tag invalid, counter 0, Stall=0 next cycle. No forwarding from the killed instruction.
6. Reset_n pulsed low mid HOLD (LOAD_LAT=3, counter=2) -> Stall, ForwardA and ForwardB go to 0 immediately without a clock, and stay 0 after release until new tags arrive.
